crc32_frame_sequencer: RTL and testbench
========================================

# crc32_frame_sequencer

Byte-stream front end for the existing bit-serial CRC-32 engine. Accepts message bytes over a valid/ready stream, opens each message with a one-cycle `new_message` pulse, and serializes each byte LSB-first into the engine at one bit per clock. After the engine's output-settle delay, it presents the final CRC and the frame byte count on a held valid/ready result port. It sits between a packet source (framer, DMA) and any CRC consumer (FCS append/check).

## Interface
- `LEN_W`, default 16: width of the frame byte counter.
- `DRAIN_CYCLES`, default 2: cycles between the last `enable` bit and a settled `crc_out` of the engine.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset; also drives the engine's `rst_n` as `~rst`.
- `s_valid`  in  1  source byte valid.
- `s_ready`  out  1  sequencer accepts the byte this cycle.
- `s_data`  in  8  message byte, sent LSB first.
- `s_last`  in  1  the byte is the final byte of the frame.
- `abort`  in  1  synchronous frame drop.
- `m_valid`  out  1  result valid, held until accepted.
- `m_ready`  in  1  result consumer ready.
- `m_crc`  out  32  final CRC (engine `crc_out`, already reflected and inverted).
- `m_len`  out  LEN_W  byte count of the frame.
- `m_ovf`  out  1  byte count saturated during this frame.

## Operation
- FSM states: IDLE, INIT, LOAD, SHIFT, DRAIN, RESULT.
- IDLE: `s_ready`=0. If `s_valid`=1, go to INIT. The byte is not consumed.
- INIT: drive engine `new_message`=1 and `enable`=0 for exactly one cycle. Clear the byte counter, `m_ovf`, and the bit index. Go to LOAD.
- LOAD: `s_ready`=1. On handshake, capture `s_data` into an 8-bit shift register, capture `s_last` into `last_q`, increment the count, and go to SHIFT with bit index 0. If there is no handshake, stay in LOAD. `enable` stays 0, so gaps are legal.
- SHIFT: engine `enable`=1 and `data_in`=shreg[0]. Each cycle, shift right and increment the bit index.
  - On bit index 7 with `last_q`=0, `s_ready`=1. A handshake here reloads shreg and continues SHIFT at bit 0 with no bubble. Without a handshake, go to LOAD.
  - On bit index 7 with `last_q`=1, `s_ready`=0 and go to DRAIN.
- DRAIN: `enable`=0 for DRAIN_CYCLES cycles (down-counter), then go to RESULT and latch `m_crc` from `crc_out`.
- RESULT: `m_valid`=1. `m_crc`, `m_len` and `m_ovf` are stable until `m_valid && m_ready`, then go to IDLE.
- Count: increments per accepted byte and saturates at 2^LEN_W−1. Reaching saturation sets `m_ovf` sticky for the frame.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE.
  - `s_ready` is forced to 0 in that cycle, so no byte is consumed.
  - Engine `enable` is forced to 0.
  - A pending result is discarded and `m_valid` falls next cycle.
- `abort` in IDLE has no effect.
- Engine inputs outside SHIFT/INIT: `enable`=0, `new_message`=0, `data_in`=0.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `m_crc`=0, `m_len`=0, `m_ovf`=0. State is IDLE and the engine is held in reset.
- Cycle 0 is the first cycle with `s_valid`=1 in IDLE. INIT occurs at cycle 1 and the first handshake at cycle 2 (LOAD).
- With a source that is always valid, bits of byte k go out at cycles 3+8k … 10+8k.
- For an N-byte frame, `m_valid` first rises at cycle 8N+3+DRAIN_CYCLES, which is cycle 8N+5 at the default.
- Sustained throughput is 1 bit/clock (8 clocks/byte). Each frame has an overhead of 3+DRAIN_CYCLES cycles plus the result handshake.
- `m_ready` may be high before `m_valid`. The result is then accepted in the first RESULT cycle and IDLE follows next cycle.
- The next frame cannot start until IDLE is reached. A one-byte frame (s_last on the first byte) is legal.
- A mid-frame `rst` forces outputs to their reset values immediately (asynchronously) and resets the engine.

## Structure
- Package `crc32_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - `CRC32_CHECK_123456789 = 32'hCBF43926`;
  - the default `DRAIN_CYCLES`.
- One sub-module: the existing `serial_crc32_generator`, instantiated as `u_crc`. The FSM, shifter, bit index, drain counter and byte counter stay in the top module.

## Test plan
- Send "123456789" (0x31…0x39, s_last on 0x39) back-to-back → `m_crc`=32'hCBF43926, `m_len`=9, `m_ovf`=0, `m_valid` rises at cycle 77.
- Send 4×0x00, then 4×0xFF, then 8 walking-ones bytes 0x01…0x80, each as a separate frame → 32'h2144DF1C, 32'hFFFFFFFF, 32'hE0631A53 in order. `new_message` pulses once per frame.
- Run 4×0x55 with `s_valid` deasserted for 3 cycles between every byte, and hold `m_ready`=0 for 5 RESULT cycles → `m_crc`=32'h6B2DC0BD, held stable until the handshake, then `s_ready`=0 and IDLE.
- Assert `abort` during SHIFT of byte 3 of "123456789", then send 4×0xAA → the aborted frame produces no `m_valid`. The new frame gives 32'hB596E05E with `m_len`=4.
- Use LEN_W=3 and send a 9-byte frame → `m_len`=7 and `m_ovf`=1, with the CRC still 32'hCBF43926.
- Assert `rst` mid-SHIFT → all outputs are 0 immediately. A following "123456789" frame gives 32'hCBF43926.

Source files
------------

// File: rtl/crc32_seq_pkg.sv
// Shared types and constants for the CRC-32 frame sequencer.
//   seq_state_t            sequencer FSM state encoding
//   CRC32_CHECK_123456789  CRC-32 of ASCII "123456789"
//   CRC32_POLY_REFLECTED   bit-reversed IEEE 802.3 polynomial
//   DRAIN_CYCLES_DEFAULT   default settle delay of the serial engine
package crc32_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StLoad,
        StShift,
        StDrain,
        StResult
    } seq_state_t;

    localparam logic [31:0] CRC32_CHECK_123456789 = 32'hCBF43926;
    localparam logic [31:0] CRC32_POLY_REFLECTED  = 32'hEDB88320;
    localparam int unsigned DRAIN_CYCLES_DEFAULT  = 2;

endpackage

// File: rtl/serial_crc32_generator.sv
// Bit-serial CRC-32 engine (reflected, LSB-first, init all-ones, final inversion).
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   new_message  preset the LFSR to all-ones for a new message
//   enable       shift data_in into the LFSR this cycle
//   data_in      message bit
//   crc_out      registered, inverted CRC; settles two cycles after the last enable
module serial_crc32_generator
    import crc32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_message,
    input  logic        enable,
    input  logic        data_in,
    output logic [31:0] crc_out
);

    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] crc_out_q;
    logic        fb;

    always_comb begin
        lfsr_d = lfsr_q;
        fb     = lfsr_q[0] ^ data_in;
        if (new_message) begin
            lfsr_d = '1;
        end else if (enable) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (fb ? CRC32_POLY_REFLECTED : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q    <= '1;
            crc_out_q <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            crc_out_q <= ~lfsr_q;
        end
    end

    assign crc_out = crc_out_q;

endmodule

// File: rtl/crc32_frame_sequencer.sv
// Byte-stream front end for the serial CRC-32 engine. Frames bytes from a
// valid/ready source, shifts them LSB-first into the engine one bit per clock,
// waits for the engine to settle and presents CRC, length and overflow on a
// held valid/ready result port.
//   clk, rst                 clock; asynchronous active-high reset
//   s_valid/s_ready          source byte handshake
//   s_data, s_last           byte and end-of-frame marker
//   abort                    synchronous frame drop (ignored in idle)
//   m_valid/m_ready          result handshake
//   m_crc, m_len, m_ovf      final CRC, saturating byte count, saturation flag
module crc32_frame_sequencer
    import crc32_seq_pkg::*;
#(
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             abort,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_crc,
    output logic [LEN_W-1:0] m_len,
    output logic             m_ovf
);

    localparam int unsigned      DrainW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [LEN_W-1:0] LenMax = '1;

    seq_state_t        state_q, state_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              last_q, last_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       crc_q, crc_d;

    logic              abort_act;
    logic              take;
    logic [LEN_W-1:0]  count_inc;
    logic              eng_rst_n;
    logic              eng_new;
    logic              eng_en;
    logic              eng_din;
    logic [31:0]       eng_crc;

    assign abort_act = abort && (state_q != StIdle);
    assign count_inc = (count_q == LenMax) ? LenMax : count_q + LEN_W'(1);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        bit_idx_d = bit_idx_q;
        drain_d   = drain_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        crc_d     = crc_q;
        s_ready   = 1'b0;
        eng_new   = 1'b0;
        eng_en    = 1'b0;
        eng_din   = 1'b0;
        take      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s_valid) state_d = StInit;
            end
            StInit: begin
                eng_new   = 1'b1;
                count_d   = '0;
                ovf_d     = 1'b0;
                bit_idx_d = '0;
                state_d   = StLoad;
            end
            StLoad: begin
                s_ready = 1'b1;
                take    = s_valid;
            end
            StShift: begin
                eng_en    = 1'b1;
                eng_din   = shreg_q[0];
                shreg_d   = {1'b0, shreg_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    if (last_q) begin
                        drain_d = DrainW'(DRAIN_CYCLES);
                        state_d = StDrain;
                    end else begin
                        // Offer the next byte on the final bit so streams run bubble-free.
                        s_ready = 1'b1;
                        take    = s_valid;
                        if (!s_valid) state_d = StLoad;
                    end
                end
            end
            StDrain: begin
                if (drain_q <= DrainW'(1)) begin
                    crc_d   = eng_crc;
                    state_d = StResult;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            StResult: begin
                if (m_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (take && !abort_act) begin
            shreg_d   = s_data;
            last_d    = s_last;
            bit_idx_d = '0;
            count_d   = count_inc;
            ovf_d     = ovf_q | (count_inc == LenMax);
            state_d   = StShift;
        end

        if (abort_act) begin
            s_ready = 1'b0;
            eng_en  = 1'b0;
            eng_din = 1'b0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            last_q    <= 1'b0;
            bit_idx_q <= '0;
            drain_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            crc_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            bit_idx_q <= bit_idx_d;
            drain_q   <= drain_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            crc_q     <= crc_d;
        end
    end

    assign m_valid   = (state_q == StResult);
    assign m_crc     = crc_q;
    assign m_len     = count_q;
    assign m_ovf     = ovf_q;
    assign eng_rst_n = ~rst;

    serial_crc32_generator u_crc (
        .clk         (clk),
        .rst_n       (eng_rst_n),
        .new_message (eng_new),
        .enable      (eng_en),
        .data_in     (eng_din),
        .crc_out     (eng_crc)
    );

endmodule

// File: tb/tb_crc32_frame_sequencer.sv
// Self-checking bench for crc32_frame_sequencer: directed frames from the test
// plan plus random frames, checked against a byte-level CRC-32 reference.
// A second instance with LEN_W=3 runs on the same stimulus to cover saturation.
module tb_crc32_frame_sequencer;
    import crc32_seq_pkg::*;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [31:0] crc;
        int          n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_last, abort, m_ready;
    logic [7:0]  s_data;
    logic        s_ready, m_valid, m_ovf;
    logic [31:0] m_crc;
    logic [15:0] m_len;
    logic        s_ready3, m_valid3, m_ovf3;
    logic [31:0] m_crc3;
    logic [2:0]  m_len3;

    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   nm_pulses = 0;
    int   frames_started = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   hold_mode = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (u_dut.u_crc.new_message) nm_pulses++;

    crc32_frame_sequencer #(.LEN_W(16), .DRAIN_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .abort(abort), .m_valid(m_valid), .m_ready(m_ready),
        .m_crc(m_crc), .m_len(m_len), .m_ovf(m_ovf)
    );

    crc32_frame_sequencer #(.LEN_W(3), .DRAIN_CYCLES(2)) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
        .s_last(s_last), .abort(abort), .m_valid(m_valid3), .m_ready(m_ready),
        .m_crc(m_crc3), .m_len(m_len3), .m_ovf(m_ovf3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Standard byte-at-a-time reflected CRC-32.
    function automatic logic [31:0] ref_crc(input bytes_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Result monitor: drives m_ready, checks results and their stability.
    initial begin
        logic        prev_valid = 1'b0;
        logic        after_accept = 1'b0;
        int          vcnt = 0;
        logic [31:0] held_crc = '0;
        logic [15:0] held_len = '0;
        exp_t        e;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (after_accept) begin
                check_eq("idle_valid", {63'h0, m_valid}, 64'h0);
                check_eq("idle_ready", {63'h0, s_ready}, 64'h0);
                check_eq("idle_ready3", {63'h0, s_ready3}, 64'h0);
                after_accept = 1'b0;
            end
            if (m_valid && !prev_valid) begin
                rise_cyc = cyc;
                vcnt     = 0;
                held_crc = m_crc;
                held_len = m_len;
                if (sb.size() == 0) check_eq("spurious_valid", {63'h0, m_valid}, 64'h0);
            end
            if (m_valid) begin
                vcnt++;
                check_eq("hold_crc", m_crc, held_crc);
                check_eq("hold_len", m_len, held_len);
                m_ready = (hold_mode != 0) ? (vcnt > 5) : 1'($urandom_range(0, 1));
                if (m_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("crc", m_crc, e.crc);
                    check_eq("len", m_len, e.n);
                    check_eq("ovf", {63'h0, m_ovf}, 64'h0);
                    check_eq("valid3", {63'h0, m_valid3}, 64'h1);
                    check_eq("crc3", m_crc3, e.crc);
                    check_eq("len3", m_len3, (e.n > 7) ? 7 : e.n);
                    check_eq("ovf3", {63'h0, m_ovf3}, (e.n >= 7) ? 64'h1 : 64'h0);
                    if (hold_mode != 0) check_eq("hold_cycles", vcnt, 6);
                    after_accept = 1'b1;
                end
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            prev_valid = m_valid;
        end
    end

    // Called just after a negedge; returns just after a negedge.
    task automatic send_frame(input bytes_t b, input int gap, input int abort_after,
                              input logic [31:0] exp_crc);
        logic hs;
        exp_t e;
        frames_started++;
        if (abort_after < 0) begin
            e.crc = exp_crc;
            e.n   = b.size();
            sb.push_back(e);
        end
        foreach (b[i]) begin
            s_valid = 1'b1;
            s_data  = b[i];
            s_last  = (i == b.size() - 1);
            if (i == 0) start_cyc = cyc;
            hs = 1'b0;
            for (int k = 0; k < 200 && !hs; k++) begin
                #1;
                hs = s_ready;
                @(negedge clk);
            end
            if (!hs) begin
                check_eq("hs_timeout", {63'h0, hs}, 64'h1);
                s_valid = 1'b0;
                return;
            end
            if (i == abort_after) begin
                s_valid = 1'b0;
                repeat (3) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                s_last = 1'b0;
                return;
            end
            if (gap > 0 && i != b.size() - 1) begin
                s_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_results();
        for (int k = 0; k < 3000 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            check_eq("result_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_ready"}, {63'h0, s_ready}, 64'h0);
        check_eq({tag, "_m_valid"}, {63'h0, m_valid}, 64'h0);
        check_eq({tag, "_m_crc"}, m_crc, 64'h0);
        check_eq({tag, "_m_len"}, m_len, 64'h0);
        check_eq({tag, "_m_ovf"}, {63'h0, m_ovf}, 64'h0);
        check_eq({tag, "_m_valid3"}, {63'h0, m_valid3}, 64'h0);
        check_eq({tag, "_m_crc3"}, m_crc3, 64'h0);
    endtask

    initial begin
        bytes_t b, digits;
        logic   hs;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; abort = 1'b0;
        digits = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // "123456789" back-to-back, with first-valid latency check.
        send_frame(digits, 0, -1, CRC32_CHECK_123456789);
        wait_results();
        check_eq("rise_cycle", rise_cyc - start_cyc, 77);

        // Directed patterns, one frame each.
        b = {8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(b, 0, -1, 32'h2144DF1C);
        b = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(b, 0, -1, 32'hFFFFFFFF);
        b.delete();
        for (int i = 0; i < 8; i++) b.push_back(8'(1 << i));
        send_frame(b, 0, -1, 32'hE0631A53);
        wait_results();

        // Gapped source and a consumer that stalls for five result cycles.
        hold_mode = 1;
        b = {8'h55, 8'h55, 8'h55, 8'h55};
        send_frame(b, 3, -1, 32'h6B2DC0BD);
        wait_results();
        hold_mode = 0;

        // Abort during byte 3, then a clean frame.
        send_frame(digits, 0, 2, 32'h0);
        repeat (100) @(negedge clk);
        b = {8'hAA, 8'hAA, 8'hAA, 8'hAA};
        send_frame(b, 0, -1, 32'hB596E05E);
        wait_results();

        // Random frames against the reference model.
        for (int f = 0; f < 14; f++) begin
            b.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) b.push_back(8'($urandom));
            send_frame(b, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 14)) : 0, -1,
                       ref_crc(b));
        end
        wait_results();

        // Asynchronous reset in the middle of SHIFT.
        frames_started++;
        s_valid = 1'b1; s_data = 8'h31; s_last = 1'b0;
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            #1;
            hs = s_ready;
            @(negedge clk);
        end
        check_eq("rst_frame_hs", {63'h0, hs}, 64'h1);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(digits, 0, -1, CRC32_CHECK_123456789);
        wait_results();

        check_eq("new_message_count", nm_pulses, frames_started);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
